// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with runtime-loadable pattern and overlap select.
// Optional saturating match counter is built when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_param #(
  parameter int                 SEQ_LEN   = 3,
  parameter logic [SEQ_LEN-1:0] PAT_RESET = 3'b110,
  parameter int                 CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic [SEQ_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               det,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int                FILL_W   = $clog2(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN - 1);

  logic [SEQ_LEN-1:0] pat_q, pat_d;
  logic [SEQ_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;

  logic [SEQ_LEN-1:0] window;
  logic               accept;
  logic               armed;
  logic               hit;

  // fill_q encodes EMPTY (0), FILLING and ARMED (SEQ_LEN-1)
  assign accept = in_valid & ~pat_load;
  assign window = {hist_q, in_bit};
  assign armed  = (fill_q == FILL_MAX);
  assign hit    = accept & armed & (window == pat_q);
  assign det    = hit;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = window[SEQ_LEN-2:0];
      if (hit && !overlap_en) begin
        fill_d = '0;
      end else if (!armed) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= PAT_RESET;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // clear takes priority over a detection in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (hit) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three instances (3-bit/8-bit count, 4-bit pattern,
// 3-bit/2-bit count) share one stimulus stream; each scenario checks the relevant instance.
module tb_seq_detector_param;

`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       overlap_en;
  logic       pat_load;
  logic [2:0] pat_in3;
  logic [3:0] pat_in4;
  logic       cnt_clr;
  logic       det_a, det_b, det_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int errors = 0;
  int checks = 0;

  seq_detector_param #(.SEQ_LEN(3), .PAT_RESET(3'b110), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in3), .cnt_clr(cnt_clr), .det(det_a), .match_cnt(cnt_a)
  );

  seq_detector_param #(.SEQ_LEN(4), .PAT_RESET(4'b1010), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in4), .cnt_clr(cnt_clr), .det(det_b), .match_cnt(cnt_b)
  );

  seq_detector_param #(.SEQ_LEN(3), .PAT_RESET(3'b110), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in3), .cnt_clr(cnt_clr), .det(det_c), .match_cnt(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; det is read 1ns later, well before the next rising edge.
  task automatic drive(input logic v, input logic b, input logic ld, input logic clr);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    pat_load = ld;
    cnt_clr  = clr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    // hold reset while offering valid 1s; none of them may be accepted
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (det_a !== 1'b0) begin errors++; $display("FAIL reset_det det=%b exp=0", det_a); end
    checks++;
    if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_cnt_a cnt=%0d exp=0", cnt_a); end
    checks++;
    if (cnt_c !== 2'd0) begin errors++; $display("FAIL reset_cnt_c cnt=%0d exp=0", cnt_c); end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (det_a !== 1'b0) begin errors++; $display("FAIL reset_hist det=%b exp=0", det_a); end
  endtask

  task automatic test_overlap_110();
    logic [5:0] bits = 6'b110110;
    logic [5:0] expd = 6'b001001;
    do_reset();
    overlap_en = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 1'b0);
      checks++;
      if (det_a !== expd[i]) begin
        errors++; $display("FAIL ovl110 bit%0d det=%b exp=%b", 6 - i, det_a, expd[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt_a !== (CNT_ON ? 8'd2 : 8'd0)) begin
      errors++; $display("FAIL ovl110_cnt cnt=%0d exp=%0d", cnt_a, CNT_ON ? 2 : 0);
    end
  endtask

  task automatic test_load_111();
    logic [4:0] exp_ov = 5'b00111;
    logic [4:0] exp_no = 5'b00100;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      overlap_en = (m == 0);
      pat_in3    = 3'b111;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (det_a !== 1'b0) begin errors++; $display("FAIL load111_ldcyc ov=%0d det=%b exp=0", 1 - m, det_a); end
      for (int i = 4; i >= 0; i--) begin
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (det_a !== (m == 0 ? exp_ov[i] : exp_no[i])) begin
          errors++;
          $display("FAIL load111 ov=%0d bit%0d det=%b exp=%b", 1 - m, 5 - i, det_a,
                   m == 0 ? exp_ov[i] : exp_no[i]);
        end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cnt_a !== (CNT_ON ? (m == 0 ? 8'd3 : 8'd1) : 8'd0)) begin
        errors++; $display("FAIL load111_cnt ov=%0d cnt=%0d", 1 - m, cnt_a);
      end
    end
  endtask

  task automatic test_seq4();
    logic [5:0] bits   = 6'b101010;
    logic [5:0] exp_no = 6'b000100;
    logic [5:0] exp_ov = 6'b000101;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      overlap_en = (m == 1);
      for (int i = 5; i >= 0; i--) begin
        drive(1'b1, bits[i], 1'b0, 1'b0);
        checks++;
        if (det_b !== (m == 1 ? exp_ov[i] : exp_no[i])) begin
          errors++;
          $display("FAIL seq4 ov=%0d bit%0d det=%b exp=%b", m, 6 - i, det_b,
                   m == 1 ? exp_ov[i] : exp_no[i]);
        end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cnt_b !== (CNT_ON ? (m == 1 ? 8'd2 : 8'd1) : 8'd0)) begin
        errors++; $display("FAIL seq4_cnt ov=%0d cnt=%0d", m, cnt_b);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [2:0] bits = 3'b110;
    logic [2:0] expd = 3'b001;
    do_reset();
    overlap_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    // short asynchronous pulse that falls and rises between clock edges
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (det_a !== 1'b0) begin errors++; $display("FAIL midrst_first det=%b exp=0", det_a); end
    for (int i = 2; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 1'b0);
      checks++;
      if (det_a !== expd[i]) begin
        errors++; $display("FAIL midrst bit%0d det=%b exp=%b", 3 - i, det_a, expd[i]);
      end
    end
  endtask

  task automatic test_bubbles_load();
    logic [2:0] bits = 3'b110;
    logic [2:0] expd = 3'b001;
    do_reset();
    overlap_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (det_a !== 1'b0) begin errors++; $display("FAIL bubble_det det=%b exp=0", det_a); end
    pat_in3 = 3'b110;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (det_a !== 1'b0) begin errors++; $display("FAIL load_wins det=%b exp=0", det_a); end
    for (int i = 2; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 1'b0);
      checks++;
      if (det_a !== expd[i]) begin
        errors++; $display("FAIL after_load bit%0d det=%b exp=%b", 3 - i, det_a, expd[i]);
      end
    end
  endtask

  task automatic test_saturate_clr();
    logic [2:0] bits = 3'b110;
    do_reset();
    overlap_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 2; i >= 0; i--) drive(1'b1, bits[i], 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt_c !== (CNT_ON ? 2'd3 : 2'd0)) begin
      errors++; $display("FAIL sat_cnt_c cnt=%0d exp=%0d", cnt_c, CNT_ON ? 3 : 0);
    end
    checks++;
    if (cnt_a !== (CNT_ON ? 8'd5 : 8'd0)) begin
      errors++; $display("FAIL nosat_cnt_a cnt=%0d exp=%0d", cnt_a, CNT_ON ? 5 : 0);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (det_c !== 1'b1) begin errors++; $display("FAIL clr_det det=%b exp=1", det_c); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt_c !== 2'd0) begin errors++; $display("FAIL clr_wins cnt=%0d exp=0", cnt_c); end
  endtask

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    overlap_en = 1'b1;
    pat_load   = 1'b0;
    pat_in3    = 3'b000;
    pat_in4    = 4'b0000;
    cnt_clr    = 1'b0;
    test_reset();
    test_overlap_110();
    test_load_111();
    test_seq4();
    test_reset_midstream();
    test_bubbles_load();
    test_saturate_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
